// File: rtl/f1_pkg.sv
// ============================================================================
//  f1_pkg : shared state type and default sizes for the F1 start-light block.
//  F1_REACTION_EN adds the REACT state.   Rev 1.0
// ============================================================================
`default_nettype none

package f1_pkg;

  localparam int NUM_LIGHTS_DFLT = 8;
  localparam int DELAY_W_DFLT    = 7;
  localparam int RT_W_DFLT       = 16;

`ifdef F1_REACTION_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2,
    REACT = 2'd3
  } f1_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } f1_state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/f1_hold_timer.sv
// ============================================================================
//  f1_hold_timer : loadable down-counter, decremented on dec_i, stops at zero.
//  Rev 1.0
// ============================================================================
`default_nettype none

module f1_hold_timer #(
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DELAY_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DELAY_W-1:0] cnt_q;
  logic [DELAY_W-1:0] cnt_d;

  // Load wins over decrement; the counter never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/f1_light_seq.sv
// ============================================================================
//  f1_light_seq : F1 start-light sequencer (fill, random hold, lights-out).
//  Optional reaction timer with F1_REACTION_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module f1_light_seq
  import f1_pkg::*;
#(
  parameter int NUM_LIGHTS = NUM_LIGHTS_DFLT,
  parameter int DELAY_W    = DELAY_W_DFLT,
  parameter int RT_W       = RT_W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger_i,
  input  logic                  tick_i,
  input  logic                  abort_i,
  input  logic [DELAY_W-1:0]    delay_val_i,
`ifdef F1_REACTION_EN
  input  logic                  react_i,
  output logic [RT_W-1:0]       react_time_o,
  output logic                  react_valid_o,
  output logic                  jump_start_o,
`endif
  output logic [NUM_LIGHTS-1:0] data_out_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int LIT_W = $clog2(NUM_LIGHTS + 1);

  if ((NUM_LIGHTS < 2) || (NUM_LIGHTS > 32) || (DELAY_W < 1) || (RT_W < 1)) begin : g_bad_param
    $error("f1_light_seq: parameter out of range");
  end

  f1_state_t             state_q, state_d;
  logic [LIT_W-1:0]      lit_q, lit_d;
  logic [NUM_LIGHTS-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  hold_load, hold_dec, hold_zero;

`ifdef F1_REACTION_EN
  logic [RT_W-1:0]       rt_cnt_q, rt_cnt_d;
  logic [RT_W-1:0]       rt_q, rt_d;
  logic                  rv_q, rv_d;
  logic                  js_q, js_d;
`endif

  f1_hold_timer #(.DELAY_W(DELAY_W)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load),
    .load_val_i (delay_val_i),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

  always_comb begin
    state_d   = state_q;
    lit_d     = lit_q;
    data_d    = data_q;
    done_d    = 1'b0;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
`ifdef F1_REACTION_EN
    rt_cnt_d  = rt_cnt_q;
    rt_d      = rt_q;
    rv_d      = 1'b0;
    js_d      = js_q;
`endif
    if (abort_i) begin
      state_d = IDLE;
      lit_d   = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          data_d = '0;
          if (trigger_i) begin
            state_d = FILL;
            lit_d   = '0;
`ifdef F1_REACTION_EN
            js_d    = 1'b0;
`endif
          end
        end
        FILL: begin
          if (tick_i) begin
            data_d = {data_q[NUM_LIGHTS-2:0], 1'b1};
            lit_d  = lit_q + 1'b1;
            // Last lamp: load the hold phase on the same tick.
            if (lit_q == LIT_W'(NUM_LIGHTS - 1)) begin
              state_d   = HOLD;
              hold_load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick_i) begin
            if (hold_zero) begin
              data_d = '0;
              done_d = 1'b1;
              lit_d  = '0;
`ifdef F1_REACTION_EN
              state_d  = REACT;
              rt_cnt_d = '0;
`else
              state_d  = IDLE;
`endif
            end else begin
              hold_dec = 1'b1;
            end
          end
        end
`ifdef F1_REACTION_EN
        REACT: begin
          if (react_i) begin
            rt_d    = rt_cnt_q;
            rv_d    = 1'b1;
            state_d = IDLE;
          end else if (rt_cnt_q != '1) begin
            rt_cnt_d = rt_cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          data_d  = '0;
          lit_d   = '0;
        end
      endcase
`ifdef F1_REACTION_EN
      // A press while the lamps are still sequencing is a false start.
      if (react_i && ((state_q == FILL) || (state_q == HOLD))) begin
        js_d = 1'b1;
        rt_d = '1;
        rv_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lit_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
`ifdef F1_REACTION_EN
      rt_cnt_q <= '0;
      rt_q     <= '0;
      rv_q     <= 1'b0;
      js_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lit_q    <= lit_d;
      data_q   <= data_d;
      done_q   <= done_d;
`ifdef F1_REACTION_EN
      rt_cnt_q <= rt_cnt_d;
      rt_q     <= rt_d;
      rv_q     <= rv_d;
      js_q     <= js_d;
`endif
    end
  end

  assign data_out_o = data_q;
  assign busy_o     = (state_q == FILL) || (state_q == HOLD);
  assign done_o     = done_q;
`ifdef F1_REACTION_EN
  assign react_time_o  = rt_q;
  assign react_valid_o = rv_q;
  assign jump_start_o  = js_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_f1_light_seq.sv
// ============================================================================
//  tb_f1_light_seq : randomized + directed bench with a queue scoreboard.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_f1_light_seq;

  localparam int N   = 8;
  localparam int DW  = 7;
  localparam int RTW = 16;
`ifdef F1_REACTION_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, trigger, tick, abort, react;
  logic [DW-1:0]  delay_val;
  logic [N-1:0]   data_out;
  logic           busy, done;
  logic [RTW-1:0] react_time;
  logic           react_valid, jump_start;

  always #5 clk = ~clk;

  f1_light_seq #(.NUM_LIGHTS(N), .DELAY_W(DW), .RT_W(RTW)) dut (
    .clk           (clk),
    .rst           (rst),
    .trigger_i     (trigger),
    .tick_i        (tick),
    .abort_i       (abort),
    .delay_val_i   (delay_val),
`ifdef F1_REACTION_EN
    .react_i       (react),
    .react_time_o  (react_time),
    .react_valid_o (react_valid),
    .jump_start_o  (jump_start),
`endif
    .data_out_o    (data_out),
    .busy_o        (busy),
    .done_o        (done)
  );

`ifndef F1_REACTION_EN
  assign react_time  = '0;
  assign react_valid = 1'b0;
  assign jump_start  = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]   data;
    logic           busy;
    logic           done;
    logic [RTW-1:0] rt;
    logic           rv;
    logic           js;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: a run is "k ticks since start"; lamps = min(k, N), out at tick N+D+1.
  bit             m_run, m_react, m_done, m_rv, m_js;
  int             m_k, m_d, m_rtc;
  logic [RTW-1:0] m_rt;

  task automatic model_step(bit r, bit a, bit t, bit tk, int d, bit rc);
    m_done = 1'b0;
    m_rv   = 1'b0;
    if (r) begin
      m_run = 0; m_react = 0; m_k = 0; m_rt = '0; m_js = 0; m_rtc = 0;
    end else if (a) begin
      m_run = 0; m_react = 0; m_k = 0;
    end else if (m_run) begin
      if (FEAT && rc) begin
        m_js = 1; m_rt = '1; m_rv = 1;
      end
      if (tk) begin
        m_k++;
        if (m_k == N) m_d = d;
        if (m_k == N + m_d + 1) begin
          m_run = 0; m_done = 1; m_react = FEAT; m_rtc = 0;
        end
      end
    end else if (m_react) begin
      if (rc) begin
        m_rt = RTW'(m_rtc); m_rv = 1; m_react = 0;
      end else if (m_rtc < (1 << RTW) - 1) begin
        m_rtc++;
      end
    end else if (t) begin
      m_run = 1; m_k = 0; m_js = 0;
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    logic [63:0] v;
    v = 64'd1 << ((m_k >= N) ? N : m_k);
    v = v - 64'd1;
    s.data = m_run ? v[N-1:0] : '0;
    s.busy = m_run;
    s.done = m_done;
    s.rt   = m_rt;
    s.rv   = m_rv;
    s.js   = m_js;
    return s;
  endfunction

  task automatic step(bit r, bit a, bit t, bit tk, int d, bit rc);
    rst = r; abort = a; trigger = t; tick = tk; delay_val = DW'(d); react = rc;
    model_step(r, a, t, tk, d, rc);
    exp_q.push_back(model_snap());
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Trigger, then tick (with gaps) until lights-out, bounded.
  task automatic full_run(int d);
    int guard;
    step(0, 0, 1, 0, d, 0);
    guard = 0;
    while (m_run && guard < 400) begin
      step(0, 0, 0, 1, d, 0);
      if (guard % 3 == 1) step(0, 0, 0, 0, d, 0);
      guard++;
    end
    total++;
    if (m_run) begin
      bad++;
      $display("FAIL full_run_bound: still running after %0d ticks, required lights-out", guard);
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        if (FEAT) begin
          check("react_time", 32'(react_time), 32'(e.rt));
          check("react_valid", 32'(react_valid), 32'(e.rv));
          check("jump_start", 32'(jump_start), 32'(e.js));
        end
      end
    end
  end

  initial begin
    m_run = 0; m_react = 0; m_k = 0; m_d = 0; m_rtc = 0; m_rt = '0;
    m_js = 0; m_done = 0; m_rv = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(2);

    // rst for 3 cycles with 4 lamps lit, then restart from zero lamps
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // full fill with hold of 3, then hold of 0
    full_run(3);
    idle(3);
    full_run(0);
    idle(3);

    // trigger and tick in the same idle cycle; trigger during FILL
    step(0, 0, 1, 1, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    step(0, 0, 1, 1, 2, 0);
    step(0, 0, 1, 0, 2, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 5, 0);
    step(0, 0, 0, 1, 5, 0);
    // abort in HOLD
    step(0, 1, 0, 1, 0, 0);
    idle(2);
    if (FEAT) begin
      step(0, 0, 0, 0, 0, 1);
      full_run(1);
      idle(50);
      step(0, 0, 0, 0, 0, 1);
      idle(2);
      // false start during FILL, sequence continues, next trigger clears it
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);
      idle(5);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      // abort in REACT keeps last react_time
      full_run(2);
      idle(4);
      step(0, 1, 0, 0, 0, 0);
      idle(2);
    end

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0),
           int'($urandom_range(0, 6)),
           FEAT && ($urandom_range(0, 24) == 0));
    end

    idle(2);
    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/f1_light_seq.md
Name: f1_light_seq

Overview:
- Parametrised F1 start-light sequencer.
- Lights NUM_LIGHTS lamps one per tick, then holds all lamps lit for a caller-supplied number of ticks, then extinguishes all lamps at once and pulses done.
- Sits between the tick generator / LFSR delay source and the LED driver.
- Generalises the fixed 8-lamp, en-stepped chain: adds variable lamp count, a start handshake, a random hold phase, abort, and an optional reaction timer.

Parameters:
- NUM_LIGHTS, 8, number of lamps (2..32).
- DELAY_W, 7, width of delay_val and of the hold counter.
- RT_W, 16, reaction-time counter width (used only with F1_REACTION_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- trigger  in  1  start request; sampled only in IDLE
- tick  in  1  single-cycle advance strobe from the tick generator
- abort  in  1  synchronous return to IDLE, lamps off
- delay_val  in  DELAY_W  hold duration in ticks; sampled on entry to HOLD
- data_out  out  NUM_LIGHTS  lamp vector; bit 0 = first lamp
- busy  out  1  high in FILL and HOLD
- done  out  1  one-cycle pulse on lights-out
- (feature) react  in  1  driver button
- (feature) react_time  out  RT_W  measured reaction time in cycles
- (feature) react_valid  out  1  one-cycle pulse when react_time is updated
- (feature) jump_start  out  1  held high from a false start until the next trigger

Behaviour:
- Reset values: data_out = 0, busy = 0, done = 0, state = IDLE, lit count = 0, hold count = 0. With the feature: react_time = 0, react_valid = 0, jump_start = 0.
- Priority order: rst > abort > normal operation.
- States: IDLE, FILL, HOLD, plus REACT when the feature is compiled in.
- IDLE
  - data_out = 0.
  - trigger = 1 -> FILL next cycle, lit = 0.
  - A tick in the same cycle as trigger is ignored.
- FILL
  - busy = 1.
  - Each tick: data_out <= {data_out[N-2:0], 1'b1}; lit <= lit + 1.
  - On the tick that makes lit == NUM_LIGHTS: go to HOLD in the same cycle and load hold <= delay_val.
  - No tick -> hold current state and lamps.
  - trigger is ignored.
- HOLD
  - data_out = all ones, busy = 1.
  - On each tick:
    - if hold == 0: data_out <= 0, done pulses the following cycle, go to IDLE (or REACT with the feature);
    - otherwise hold <= hold - 1.
  - delay_val = 0 -> lamps go out on the first tick after the last lamp lights.
  - Total lamps-on latency = NUM_LIGHTS + delay_val + 1 ticks after the first FILL tick.
- abort (any state): next cycle data_out = 0, busy = 0, state = IDLE, no done pulse.
- Lamp output is registered: data_out changes one cycle after the qualifying tick.
- Counters never wrap. lit is $clog2(NUM_LIGHTS+1) bits wide; hold stops at 0.

Optional Feature:
- F1_REACTION_EN defined:
  - After lights-out, enter REACT. An RT_W counter clears on entry and increments every clk, saturating at all ones.
  - react = 1 in REACT -> react_time <= count, react_valid pulses, go to IDLE.
  - react = 1 during FILL or HOLD -> jump_start <= 1, react_time <= all ones, react_valid pulses; the sequence continues.
  - jump_start clears on the next accepted trigger.
  - abort or rst in REACT -> IDLE; react_time keeps its last value (reset clears it).
- F1_REACTION_EN undefined:
  - The react, react_time, react_valid and jump_start ports do not exist.
  - HOLD exits directly to IDLE; the REACT state is not declared.

Decomposition:
- Package f1_pkg holds:
  - typedef enum logic [1:0] f1_state_t {IDLE, FILL, HOLD, REACT};
  - localparam defaults for NUM_LIGHTS, DELAY_W and RT_W.
- Sub-module f1_hold_timer: loadable, tick-decremented down-counter with zero flag, DELAY_W wide; instantiated once for the HOLD phase.
- The FSM, shift register and reaction counter stay in f1_light_seq.

Test Plan:
- rst high 3 cycles mid-FILL with 4 lamps lit -> data_out = 0, busy = 0 on the cycle after the first rst edge; a later trigger restarts from 0 lamps.
- NUM_LIGHTS = 8, trigger, 8 ticks -> data_out steps 0x01, 0x03, …, 0xFF, one cycle after each tick; busy = 1 throughout.
- delay_val = 3 at the 8th tick, then ticks -> 0xFF holds through 3 ticks; the 4th tick gives data_out = 0x00 and a done pulse of exactly 1 cycle.
- delay_val = 0 -> lamps out on the first tick after 0xFF. trigger plus tick in the same IDLE cycle -> no lamp lit yet.
- abort asserted in HOLD -> data_out = 0x00, busy = 0, done stays 0. trigger during FILL -> no effect.
- F1_REACTION_EN:
  - react 50 cycles after lights-out -> react_time = 50, react_valid pulses once;
  - react during FILL -> jump_start = 1, react_time = 0xFFFF;
  - next trigger clears jump_start.
